// File: rtl/byte_word_arbiter.sv
// -----------------------------------------------------------------------------
// byte_word_arbiter
//  Round-robin arbiter and sequencer that shares one 8b->32b converter between
//  two byte sources in the clk_4f domain. A source that wins arbitration owns
//  the converter for a complete word, so bytes of different words never
//  interleave. A stalled partial word is abandoned after TIMEOUT idle cycles.
//
// Ports
//  clk_4f     in   byte-rate clock, rising edge
//  reset_L    in   synchronous reset, active low
//  valid_in0  in   source 0 byte valid
//  data_in0   in   source 0 byte
//  valid_in1  in   source 1 byte valid
//  data_in1   in   source 1 byte
//  ack0       out  source 0 byte accepted this cycle (combinational)
//  ack1       out  source 1 byte accepted this cycle (combinational)
//  valid_out  out  byte to converter valid (registered)
//  data_out   out  byte to converter (registered)
//  byte_idx   out  position of data_out within its word
//  word_last  out  high with the final byte of a word
//  src_sel    out  owner of the word currently on data_out
//  abort      out  one-cycle pulse: partial word discarded by timeout
// -----------------------------------------------------------------------------
module byte_word_arbiter #(
   parameter int DATA_W         = 8,
   parameter int BYTES_PER_WORD = 4,
   parameter int TIMEOUT        = 8
) (
   input  logic                              clk_4f,
   input  logic                              reset_L,
   input  logic                              valid_in0,
   input  logic [DATA_W-1:0]                 data_in0,
   input  logic                              valid_in1,
   input  logic [DATA_W-1:0]                 data_in1,
   output logic                              ack0,
   output logic                              ack1,
   output logic                              valid_out,
   output logic [DATA_W-1:0]                 data_out,
   output logic [$clog2(BYTES_PER_WORD)-1:0] byte_idx,
   output logic                              word_last,
   output logic                              src_sel,
   output logic                              abort
);

   localparam int IW = $clog2(BYTES_PER_WORD);
   // Stall counter only has to reach TIMEOUT-1; keep at least one bit.
   localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [IW-1:0] LAST_IDX  = IW'(BYTES_PER_WORD - 1);
   localparam logic [SW-1:0] STALL_LIM = SW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t         state, state_next;
   logic           owner;
   logic           last_owner;
   logic [IW-1:0]  cnt;
   logic [SW-1:0]  stall_cnt;

   logic           winner;
   logic           sel;
   logic           accept;
   logic           is_last;
   logic           timeout_hit;

   // Arbitration, acknowledge and next-state decode.
   // NOTE: every signal gets a default at the top of always_comb so that no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      winner      = 1'b0;
      sel         = 1'b0;
      accept      = 1'b0;
      ack0        = 1'b0;
      ack1        = 1'b0;
      state_next  = state;
      is_last     = (cnt == LAST_IDX);
      timeout_hit = 1'b0;

      // Round robin only matters on a tie; a lone requester always wins.
      if (valid_in0 && valid_in1) winner = ~last_owner;
      else if (valid_in1)         winner = 1'b1;

      if (state == IDLE) begin
         sel    = winner;
         accept = valid_in0 | valid_in1;
      end else begin
         // The non-owner is locked out until the word completes or aborts.
         sel    = owner;
         accept = owner ? valid_in1 : valid_in0;
      end

      ack0 = accept & ~sel;
      ack1 = accept &  sel;

      timeout_hit = (TIMEOUT > 0) && (state == LOCK) && !accept
                    && (stall_cnt == STALL_LIM);

      if (accept)           state_next = is_last ? IDLE : LOCK;
      else if (timeout_hit) state_next = IDLE;
   end

   // NOTE: reset is synchronous, so it is tested inside the clocked block and
   // all state uses non-blocking assignments to avoid ordering races.
   always_ff @(posedge clk_4f) begin
      if (!reset_L) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_owner <= 1'b1;   // source 0 wins the first tie after reset
         cnt        <= '0;
         stall_cnt  <= '0;
         valid_out  <= 1'b0;
         data_out   <= '0;
         byte_idx   <= '0;
         word_last  <= 1'b0;
         src_sel    <= 1'b0;
         abort      <= 1'b0;
      end else begin
         state <= state_next;
         abort <= 1'b0;
         if (accept) begin
            valid_out <= 1'b1;
            data_out  <= sel ? data_in1 : data_in0;
            byte_idx  <= cnt;
            word_last <= is_last;
            src_sel   <= sel;
            owner     <= sel;
            stall_cnt <= '0;
            if (is_last) begin
               cnt        <= '0;
               last_owner <= sel;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            // data_out, byte_idx and src_sel hold their last values.
            valid_out <= 1'b0;
            word_last <= 1'b0;
            if (timeout_hit) begin
               abort      <= 1'b1;
               cnt        <= '0;
               stall_cnt  <= '0;
               last_owner <= owner;
            end else if ((TIMEOUT > 0) && (state == LOCK)) begin
               stall_cnt <= stall_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_byte_word_arbiter.sv
// -----------------------------------------------------------------------------
// tb_byte_word_arbiter
//  Drives two arbiter instances (TIMEOUT=8 and TIMEOUT=0) from the same byte
//  sources and compares every cycle against a word-level reference model.
// -----------------------------------------------------------------------------
module tb_byte_word_arbiter;

   localparam int BPW = 4;

   logic       clk_4f = 1'b0;
   logic       reset_L = 1'b0;
   logic       valid_in0 = 1'b0, valid_in1 = 1'b0;
   logic [7:0] data_in0 = '0, data_in1 = '0;

   logic       ack0_a, ack1_a, valid_out_a, word_last_a, src_sel_a, abort_a;
   logic [7:0] data_out_a;
   logic [1:0] byte_idx_a;
   logic       ack0_b, ack1_b, valid_out_b, word_last_b, src_sel_b, abort_b;
   logic [7:0] data_out_b;
   logic [1:0] byte_idx_b;

   int checks = 0;
   int errors = 0;

   always #5 clk_4f = ~clk_4f;

   byte_word_arbiter #(.DATA_W(8), .BYTES_PER_WORD(BPW), .TIMEOUT(8)) dut_a (
      .clk_4f(clk_4f), .reset_L(reset_L),
      .valid_in0(valid_in0), .data_in0(data_in0),
      .valid_in1(valid_in1), .data_in1(data_in1),
      .ack0(ack0_a), .ack1(ack1_a), .valid_out(valid_out_a),
      .data_out(data_out_a), .byte_idx(byte_idx_a), .word_last(word_last_a),
      .src_sel(src_sel_a), .abort(abort_a)
   );

   byte_word_arbiter #(.DATA_W(8), .BYTES_PER_WORD(BPW), .TIMEOUT(0)) dut_b (
      .clk_4f(clk_4f), .reset_L(reset_L),
      .valid_in0(valid_in0), .data_in0(data_in0),
      .valid_in1(valid_in1), .data_in1(data_in1),
      .ack0(ack0_b), .ack1(ack1_b), .valid_out(valid_out_b),
      .data_out(data_out_b), .byte_idx(byte_idx_b), .word_last(word_last_b),
      .src_sel(src_sel_b), .abort(abort_b)
   );

   logic [31:0] obs;
   assign obs = {ack0_a, ack1_a, valid_out_a, data_out_a, byte_idx_a,
                 word_last_a, src_sel_a, abort_a,
                 ack0_b, ack1_b, valid_out_b, data_out_b, byte_idx_b,
                 word_last_b, src_sel_b, abort_b};

   // ---------------- reference model ----------------
   // owner = -1 means no word in progress; taken = bytes already in the word.
   typedef struct packed {
      int         owner;
      int         taken;
      int         stall;
      int         last_o;
      bit         vo;
      logic [7:0] dout;
      int         idx;
      bit         wl;
      bit         ss;
      bit         ab;
   } model_t;

   model_t m_a, m_b;

   function automatic model_t model_reset();
      model_t n;
      n.owner = -1; n.taken = 0; n.stall = 0; n.last_o = 1;
      n.vo = 0; n.dout = '0; n.idx = 0; n.wl = 0; n.ss = 0; n.ab = 0;
      return n;
   endfunction

   // Returns {ack1, ack0} for the current inputs.
   function automatic logic [1:0] model_ack(model_t s, logic v0, logic v1);
      int w;
      if (s.owner < 0) begin
         if (!v0 && !v1) return 2'b00;
         if (v0 && v1) w = 1 - s.last_o;
         else          w = v1 ? 1 : 0;
      end else begin
         w = s.owner;
         if (!((w == 1) ? v1 : v0)) return 2'b00;
      end
      return (w == 1) ? 2'b10 : 2'b01;
   endfunction

   function automatic model_t model_next(model_t s, int to, logic r,
                                         logic v0, logic [7:0] d0,
                                         logic v1, logic [7:0] d1);
      model_t     n = s;
      logic [1:0] a = model_ack(s, v0, v1);
      int         w;
      if (!r) return model_reset();
      n.ab = 0;
      if (a != 2'b00) begin
         w       = a[1] ? 1 : 0;
         n.vo    = 1;
         n.dout  = (w == 1) ? d1 : d0;
         n.idx   = s.taken;
         n.wl    = (s.taken == BPW - 1);
         n.ss    = (w == 1);
         n.stall = 0;
         n.taken = s.taken + 1;
         if (n.taken == BPW) begin
            n.taken  = 0;
            n.owner  = -1;
            n.last_o = w;
         end else begin
            n.owner = w;
         end
      end else begin
         n.vo = 0;
         n.wl = 0;
         if (s.owner >= 0) begin
            n.stall = s.stall + 1;
            if (to > 0 && n.stall == to) begin
               n.ab     = 1;
               n.taken  = 0;
               n.last_o = s.owner;
               n.owner  = -1;
               n.stall  = 0;
            end
         end
      end
      return n;
   endfunction

   function automatic logic [15:0] exp_vec(model_t s);
      logic [1:0] a   = model_ack(s, valid_in0, valid_in1);
      logic [1:0] idx = s.idx[1:0];
      return {a[0], a[1], s.vo, s.dout, idx, s.wl, s.ss, s.ab};
   endfunction

   // ---------------- stimulus plumbing ----------------
   task automatic set_in(input logic r, input logic v0, input logic [7:0] d0,
                         input logic v1, input logic [7:0] d1);
      reset_L   = r;
      valid_in0 = v0;
      data_in0  = d0;
      valid_in1 = v1;
      data_in1  = d1;
      #1;
   endtask

   task automatic tick();
      @(posedge clk_4f);
      m_a = model_next(m_a, 8, reset_L, valid_in0, data_in0, valid_in1, data_in1);
      m_b = model_next(m_b, 0, reset_L, valid_in0, data_in0, valid_in1, data_in1);
      @(negedge clk_4f);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         set_in(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
         if (i > 0) begin
            checks++;
            if (obs !== {exp_vec(m_a), exp_vec(m_b)}) begin
               errors++;
               $display("FAIL reset cyc %0d: got %h want %h", i, obs, {exp_vec(m_a), exp_vec(m_b)});
            end
         end
         tick();
      end
   endtask

   task automatic test_single();
      int n_ack = 0, n_vo = 0;
      for (int i = 0; i < 7; i++) begin
         set_in(i != 0, (i >= 1 && i <= 4), 8'hFF, 1'b0, 8'h00);
         checks++;
         if (obs !== {exp_vec(m_a), exp_vec(m_b)}) begin
            errors++;
            $display("FAIL single cyc %0d: got %h want %h", i, obs, {exp_vec(m_a), exp_vec(m_b)});
         end
         n_ack += int'(ack0_a);
         n_vo  += int'(valid_out_a);
         tick();
      end
      checks++;
      if (n_ack != 4 || n_vo != 4) begin
         errors++;
         $display("FAIL single_counts: got ack0=%0d valid_out=%0d want 4 and 4", n_ack, n_vo);
      end
   endtask

   task automatic test_round_robin();
      int drops = 0;
      for (int i = 0; i < 15; i++) begin
         set_in(i != 0, (i >= 1 && i <= 12), 8'hDD, (i >= 1 && i <= 12), 8'hAA);
         checks++;
         if (obs !== {exp_vec(m_a), exp_vec(m_b)}) begin
            errors++;
            $display("FAIL round_robin cyc %0d: got %h want %h", i, obs, {exp_vec(m_a), exp_vec(m_b)});
         end
         if (i >= 2 && i <= 13 && !valid_out_a) drops++;
         tick();
      end
      checks++;
      if (drops != 0) begin
         errors++;
         $display("FAIL round_robin_gap: got %0d valid_out drops want 0", drops);
      end
   endtask

   task automatic test_short_stall();
      bit v0_pat [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      int n_ack1 = 0;
      for (int i = 0; i < 8; i++) begin
         set_in(i != 0, v0_pat[i], 8'(8'h10 + i), (i >= 2), 8'h55);
         checks++;
         if (obs !== {exp_vec(m_a), exp_vec(m_b)}) begin
            errors++;
            $display("FAIL short_stall cyc %0d: got %h want %h", i, obs, {exp_vec(m_a), exp_vec(m_b)});
         end
         if (i <= 6) n_ack1 += int'(ack1_a);
         tick();
      end
      checks++;
      if (n_ack1 != 0) begin
         errors++;
         $display("FAIL short_stall_ack1: got %0d want 0", n_ack1);
      end
   endtask

   task automatic test_timeout();
      int n_ab_a = 0, n_ab_b = 0;
      for (int i = 0; i < 18; i++) begin
         set_in(i != 0, (i >= 1 && i <= 2), 8'h20, (i >= 1), 8'h77);
         checks++;
         if (obs !== {exp_vec(m_a), exp_vec(m_b)}) begin
            errors++;
            $display("FAIL timeout cyc %0d: got %h want %h", i, obs, {exp_vec(m_a), exp_vec(m_b)});
         end
         n_ab_a += int'(abort_a);
         n_ab_b += int'(abort_b);
         tick();
      end
      checks++;
      if (n_ab_a != 1 || n_ab_b != 0) begin
         errors++;
         $display("FAIL timeout_pulses: got a=%0d b=%0d want 1 and 0", n_ab_a, n_ab_b);
      end
   endtask

   task automatic test_reset_mid_word();
      logic [7:0] d0_pat [11] = '{8'h00, 8'h31, 8'h32, 8'h33, 8'h00,
                                  8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00};
      int n_ab = 0;
      for (int i = 0; i < 11; i++) begin
         set_in(!(i == 0 || i == 4), (i >= 1 && i <= 3) || (i >= 5 && i <= 8),
                d0_pat[i], 1'b0, 8'h00);
         checks++;
         if (obs !== {exp_vec(m_a), exp_vec(m_b)}) begin
            errors++;
            $display("FAIL reset_mid cyc %0d: got %h want %h", i, obs, {exp_vec(m_a), exp_vec(m_b)});
         end
         n_ab += int'(abort_a) + int'(abort_b);
         tick();
      end
      checks++;
      if (n_ab != 0) begin
         errors++;
         $display("FAIL reset_mid_abort: got %0d pulses want 0", n_ab);
      end
   endtask

   task automatic test_no_timeout();
      int n_ack1 = 0;
      for (int i = 0; i < 60; i++) begin
         set_in(i != 0, (i >= 1 && i <= 2) || (i >= 53 && i <= 54), 8'(8'h40 + i),
                (i >= 1), 8'h99);
         checks++;
         if (obs !== {exp_vec(m_a), exp_vec(m_b)}) begin
            errors++;
            $display("FAIL no_timeout cyc %0d: got %h want %h", i, obs, {exp_vec(m_a), exp_vec(m_b)});
         end
         if (i <= 54) n_ack1 += int'(ack1_b) + int'(abort_b);
         tick();
      end
      checks++;
      if (n_ack1 != 0) begin
         errors++;
         $display("FAIL no_timeout_lockout: got %0d ack1/abort events want 0", n_ack1);
      end
   endtask

   task automatic test_random();
      int p;
      for (int i = 0; i < 600; i++) begin
         p = ((i / 40) % 3 == 0) ? 3 : ((i / 40) % 3 == 1) ? 1 : 2;
         set_in(($urandom_range(0, 79) != 0),
                ($urandom_range(0, 3) < p), 8'($urandom),
                ($urandom_range(0, 3) < p), 8'($urandom));
         checks++;
         if (obs !== {exp_vec(m_a), exp_vec(m_b)}) begin
            errors++;
            $display("FAIL random cyc %0d: got %h want %h", i, obs, {exp_vec(m_a), exp_vec(m_b)});
         end
         tick();
      end
   endtask

   initial begin
      m_a = model_reset();
      m_b = model_reset();
      @(negedge clk_4f);
      test_reset();
      test_single();
      test_round_robin();
      test_short_stall();
      test_timeout();
      test_reset_mid_word();
      test_no_timeout();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
